// File: rtl/trees_loader.sv
// trees_loader: front-end sequencer for the trees random-forest engine.
// A single 64-bit valid/ready stream either fills the tree memory (one node
// per beat) or packs the feature vector (two 32-bit features per beat).
// After the feature load it pulses start, waits for done, and returns the
// 8-bit prediction on a valid/ready output.
// N_TREES, N_NODE_AND_LEAFS and N_FEATURE/2 are expected to be at least 2.
module trees_loader #(
  parameter int N_TREES          = 16,
  parameter int N_NODE_AND_LEAFS = 256,
  parameter int N_FEATURE        = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  cmd_load_trees,
  input  logic                                  cmd_infer,
  input  logic [63:0]                           in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic                                  load_trees,
  output logic [$clog2(N_TREES)-1:0]            n_tree,
  output logic [$clog2(N_NODE_AND_LEAFS)-1:0]   n_node,
  output logic [63:0]                           tree_nodes,
  output logic [N_FEATURE-1:0][31:0]            features,
  output logic                                  start,
  input  logic                                  done,
  input  logic [7:0]                            prediction,
  output logic [7:0]                            pred_data,
  output logic                                  pred_valid,
  input  logic                                  pred_ready,
  output logic                                  busy
);

  localparam int TW     = $clog2(N_TREES);
  localparam int NW     = $clog2(N_NODE_AND_LEAFS);
  localparam int NPAIRS = N_FEATURE / 2;
  localparam int FPW    = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;

  localparam logic [TW-1:0]  TREE_LAST = TW'(N_TREES - 1);
  localparam logic [NW-1:0]  NODE_LAST = NW'(N_NODE_AND_LEAFS - 1);
  localparam logic [FPW-1:0] PAIR_LAST = FPW'(NPAIRS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_TREES,
    S_LOAD_FEAT,
    S_START,
    S_WAIT_DONE,
    S_RESULT
  } state_t;

  state_t         state;
  logic [TW-1:0]  tree_cnt;
  logic [NW-1:0]  node_cnt;
  logic [FPW-1:0] pair_cnt;
  logic           in_hs;

  // Stream readiness and busy are pure state decodes so a beat can be taken
  // in the very first cycle of a load phase.
  always_comb begin
    in_ready = (state == S_LOAD_TREES) || (state == S_LOAD_FEAT);
    busy     = (state != S_IDLE);
    in_hs    = in_valid && in_ready;
  end

  // Sequencer: command decode, tree/feature loading, start pulse, result
  // capture and hand-off. Pulsed outputs default low every cycle so a write
  // strobe or start appears only in the cycle after the event causing it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tree_cnt   <= '0;
      node_cnt   <= '0;
      pair_cnt   <= '0;
      load_trees <= 1'b0;
      n_tree     <= '0;
      n_node     <= '0;
      tree_nodes <= '0;
      features   <= '0;
      start      <= 1'b0;
      pred_data  <= '0;
      pred_valid <= 1'b0;
    end else begin
      load_trees <= 1'b0;
      start      <= 1'b0;
      case (state)
        S_IDLE: begin
          // Tree load has priority; a simultaneous infer command is dropped.
          if (cmd_load_trees) begin
            state    <= S_LOAD_TREES;
            tree_cnt <= '0;
            node_cnt <= '0;
          end else if (cmd_infer) begin
            state    <= S_LOAD_FEAT;
            pair_cnt <= '0;
          end
        end
        S_LOAD_TREES: begin
          if (in_hs) begin
            load_trees <= 1'b1;
            n_tree     <= tree_cnt;
            n_node     <= node_cnt;
            tree_nodes <= in_data;
            if (node_cnt == NODE_LAST) begin
              node_cnt <= '0;
              if (tree_cnt == TREE_LAST) begin
                state <= S_IDLE;
              end else begin
                tree_cnt <= tree_cnt + TW'(1);
              end
            end else begin
              node_cnt <= node_cnt + NW'(1);
            end
          end
        end
        S_LOAD_FEAT: begin
          if (in_hs) begin
            // Low word is the even feature, high word the odd one.
            for (int i = 0; i < NPAIRS; i++) begin
              if (pair_cnt == FPW'(i)) begin
                features[2*i]   <= in_data[31:0];
                features[2*i+1] <= in_data[63:32];
              end
            end
            if (pair_cnt == PAIR_LAST) begin
              state <= S_START;
              start <= 1'b1;
            end else begin
              pair_cnt <= pair_cnt + FPW'(1);
            end
          end
        end
        S_START: begin
          state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (done) begin
            pred_data  <= prediction;
            pred_valid <= 1'b1;
            state      <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (pred_ready) begin
            pred_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trees_loader.sv
// Self-checking bench for trees_loader with 2 trees x 4 nodes, 4 features.
// Stimulus pushes expected tree writes, feature vectors and predictions into
// queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_trees_loader;
  localparam int NT = 2;
  localparam int NN = 4;
  localparam int NF = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                cmd_load_trees = 1'b0;
  logic                cmd_infer = 1'b0;
  logic [63:0]         in_data = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic                load_trees;
  logic [0:0]          n_tree;
  logic [1:0]          n_node;
  logic [63:0]         tree_nodes;
  logic [NF-1:0][31:0] features;
  logic                start;
  logic                done = 1'b0;
  logic [7:0]          prediction = '0;
  logic [7:0]          pred_data;
  logic                pred_valid;
  logic                pred_ready = 1'b0;
  logic                busy;

  trees_loader #(
    .N_TREES(NT),
    .N_NODE_AND_LEAFS(NN),
    .N_FEATURE(NF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_load_trees(cmd_load_trees),
    .cmd_infer(cmd_infer),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .load_trees(load_trees),
    .n_tree(n_tree),
    .n_node(n_node),
    .tree_nodes(tree_nodes),
    .features(features),
    .start(start),
    .done(done),
    .prediction(prediction),
    .pred_data(pred_data),
    .pred_valid(pred_valid),
    .pred_ready(pred_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [66:0]  tq[$];   // {n_tree, n_node, tree_nodes}
  logic [127:0] fq[$];   // feature vector expected at start
  logic [7:0]   pq[$];   // prediction expected at result handshake
  logic [66:0]  mon_t;
  logic [127:0] mon_f;
  logic [7:0]   mon_p;
  bit           ok;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on each DUT presentation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (load_trees) begin
        chk("load_trees_expected", 128'(load_trees), 128'(tq.size() != 0));
        if (tq.size() != 0) begin
          mon_t = tq.pop_front();
          chk("n_tree", 128'(n_tree), 128'(mon_t[66]));
          chk("n_node", 128'(n_node), 128'(mon_t[65:64]));
          chk("tree_nodes", 128'(tree_nodes), 128'(mon_t[63:0]));
        end
      end
      if (start) begin
        chk("start_expected", 128'(start), 128'(fq.size() != 0));
        if (fq.size() != 0) begin
          mon_f = fq.pop_front();
          chk("features_at_start", 128'(features), mon_f);
        end
      end
      if (pred_valid && pred_ready) begin
        chk("pred_expected", 128'(pred_valid), 128'(pq.size() != 0));
        if (pq.size() != 0) begin
          mon_p = pq.pop_front();
          chk("pred_data", 128'(pred_data), 128'(mon_p));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic lt, input logic inf);
    cmd_load_trees = lt;
    cmd_infer      = inf;
    tick();
    cmd_load_trees = 1'b0;
    cmd_infer      = 1'b0;
  endtask

  // Present one beat; returns once the handshake edge has passed.
  task automatic send(input logic [63:0] d, output bit got);
    bit hs;
    in_valid = 1'b1;
    in_data  = d;
    got      = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hs = in_ready;
      tick();
      if (hs) begin
        got = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    chk("handshake", 128'(got), 128'(1));
  endtask

  task automatic tree_beat(input logic [63:0] d, input logic [0:0] t, input logic [1:0] n);
    bit got;
    send(d, got);
    if (got) tq.push_back({t, n, d});
    chk("load_trees_pulse", 128'(load_trees), 128'(1));
  endtask

  task automatic check_reset();
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_load_trees", 128'(load_trees), 128'(0));
    chk("rst_start", 128'(start), 128'(0));
    chk("rst_pred_valid", 128'(pred_valid), 128'(0));
    chk("rst_n_tree", 128'(n_tree), 128'(0));
    chk("rst_n_node", 128'(n_node), 128'(0));
    chk("rst_tree_nodes", 128'(tree_nodes), 128'(0));
    chk("rst_pred_data", 128'(pred_data), 128'(0));
    chk("rst_features", 128'(features), 128'(0));
  endtask

  initial begin
    #2 rst_n = 1'b0;
    tick();
    tick();
    check_reset();
    rst_n = 1'b1;
    tick();

    // Tree load, valid held high: (0,0)..(0,3),(1,0)..(1,3), data 0x10..0x17
    issue_cmd(1'b1, 1'b0);
    chk("load_busy", 128'(busy), 128'(1));
    chk("load_in_ready", 128'(in_ready), 128'(1));
    tree_beat(64'h10, 1'b0, 2'd0);
    tree_beat(64'h11, 1'b0, 2'd1);
    tree_beat(64'h12, 1'b0, 2'd2);
    tree_beat(64'h13, 1'b0, 2'd3);
    tree_beat(64'h14, 1'b1, 2'd0);
    tree_beat(64'h15, 1'b1, 2'd1);
    tree_beat(64'h16, 1'b1, 2'd2);
    tree_beat(64'h17, 1'b1, 2'd3);
    chk("load_done_busy", 128'(busy), 128'(0));
    chk("load_done_in_ready", 128'(in_ready), 128'(0));

    // Feature pack: {A,B,C,D}
    issue_cmd(1'b0, 1'b1);
    send(64'h0000000B_0000000A, ok);
    chk("feat_no_early_start", 128'(start), 128'(0));
    chk("feat_in_ready", 128'(in_ready), 128'(1));
    fq.push_back({32'hD, 32'hC, 32'hB, 32'hA});
    send(64'h0000000D_0000000C, ok);
    chk("feat_start", 128'(start), 128'(1));
    chk("feat_start_in_ready", 128'(in_ready), 128'(0));
    tick();
    chk("wait_start_low", 128'(start), 128'(0));
    chk("wait_in_ready", 128'(in_ready), 128'(0));
    chk("wait_busy", 128'(busy), 128'(1));

    // Result held 5 cycles with pred_ready low
    done = 1'b1;
    prediction = 8'h03;
    tick();
    done = 1'b0;
    prediction = 8'h55;
    pq.push_back(8'h03);
    for (int i = 0; i < 5; i++) begin
      chk("result_valid_hold", 128'(pred_valid), 128'(1));
      chk("result_data_hold", 128'(pred_data), 128'(8'h03));
      tick();
    end
    chk("features_held", 128'(features), {32'hD, 32'hC, 32'hB, 32'hA});
    pred_ready = 1'b1;
    tick();
    pred_ready = 1'b0;
    chk("result_drop_valid", 128'(pred_valid), 128'(0));
    chk("result_idle", 128'(busy), 128'(0));

    // done in IDLE is ignored
    done = 1'b1;
    prediction = 8'h09;
    tick();
    done = 1'b0;
    tick();
    chk("idle_done_no_valid", 128'(pred_valid), 128'(0));
    chk("idle_done_no_busy", 128'(busy), 128'(0));

    // Stalled tree load with an ignored cmd_infer mid-load
    issue_cmd(1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("stall_no_write", 128'(load_trees), 128'(0));
      if (k == 3) cmd_infer = 1'b1;
      tree_beat(64'h20 + 64'(k), 1'(k / 4), 2'(k % 4));
      cmd_infer = 1'b0;
    end
    chk("stall_done_busy", 128'(busy), 128'(0));
    tick();
    chk("infer_not_queued", 128'(busy), 128'(0));

    // Simultaneous commands: load wins, no start afterwards
    issue_cmd(1'b1, 1'b1);
    chk("both_in_ready", 128'(in_ready), 128'(1));
    for (int k = 0; k < 8; k++) begin
      tree_beat(64'h30 + 64'(k), 1'(k / 4), 2'(k % 4));
    end
    chk("both_done_busy", 128'(busy), 128'(0));
    repeat (3) tick();
    chk("both_no_infer", 128'(busy), 128'(0));

    // Reset after the first feature beat
    issue_cmd(1'b0, 1'b1);
    send(64'h0000000F_0000000E, ok);
    rst_n = 1'b0;
    #1;
    check_reset();
    tick();
    rst_n = 1'b1;
    tick();
    issue_cmd(1'b0, 1'b1);
    send(64'h00000002_00000001, ok);
    chk("post_rst_no_start", 128'(start), 128'(0));
    chk("post_rst_in_ready", 128'(in_ready), 128'(1));
    fq.push_back({32'h4, 32'h3, 32'h2, 32'h1});
    send(64'h00000004_00000003, ok);
    chk("post_rst_start", 128'(start), 128'(1));
    tick();
    done = 1'b1;
    prediction = 8'hA5;
    tick();
    done = 1'b0;
    pq.push_back(8'hA5);
    pred_ready = 1'b1;
    tick();
    pred_ready = 1'b0;
    chk("post_rst_idle", 128'(busy), 128'(0));
    tick();

    chk("tree_q_drained", 128'(tq.size()), 128'(0));
    chk("feat_q_drained", 128'(fq.size()), 128'(0));
    chk("pred_q_drained", 128'(pq.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/trees_loader.md
# trees_loader

Front-end sequencer for the `trees` random-forest inference engine. It takes a single 64-bit valid/ready input stream and does three things: writes tree nodes into the engine's tree memory, assembles the feature vector, and pulses `start`. It then waits for `done` and returns the 8-bit class prediction on a valid/ready output. It sits between the accelerator's DMA/register front-end and `trees`, and drives every input of `trees`.

## Interface
- `N_TREES`, default 16: number of trees; must match `trees`.
- `N_NODE_AND_LEAFS`, default 256: nodes per tree; must match `trees`.
- `N_FEATURE`, default 32: feature count; must be even, because two features are packed per beat.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd_load_trees` in 1: one-cycle command that starts a tree-load phase.
- `cmd_infer` in 1: one-cycle command that starts a feature-load plus inference phase.
- `in_data` in 64: stream payload.
- `in_valid` in 1: payload valid.
- `in_ready` out 1: payload accepted when `in_valid & in_ready`.
- `load_trees` out 1: tree-memory write strobe to `trees`.
- `n_tree` out $clog2(N_TREES): tree write address.
- `n_node` out $clog2(N_NODE_AND_LEAFS): node write address.
- `tree_nodes` out 64: node write data.
- `features` out N_FEATURE×32 (packed `[N_FEATURE-1:0][31:0]`): feature vector.
- `start` out 1: inference start pulse to `trees`.
- `done` in 1: completion from `trees`.
- `prediction` in 8: class result from `trees`, valid while `done`=1.
- `pred_data` out 8: captured prediction.
- `pred_valid` out 1: prediction available.
- `pred_ready` in 1: consumer accepts the prediction.
- `busy` out 1: high in every state except IDLE.

## Operation
- **States:** IDLE, LOAD_TREES, LOAD_FEAT, START, WAIT_DONE, RESULT.
- **IDLE**
  - `cmd_load_trees` moves to LOAD_TREES and clears the tree and node counters.
  - Otherwise `cmd_infer` moves to LOAD_FEAT and clears the feature-pair counter.
  - If both commands are high in the same cycle, load wins and `cmd_infer` is dropped.
  - Commands arriving outside IDLE are ignored; they are not queued.
- **LOAD_TREES**
  - `in_ready`=1.
  - Each handshake writes one node at (tree counter, node counter).
  - The node counter increments; at N_NODE_AND_LEAFS-1 it wraps to 0 and the tree counter increments.
  - The handshake at tree N_TREES-1, node N_NODE_AND_LEAFS-1 returns to IDLE.
  - Total beats: N_TREES×N_NODE_AND_LEAFS.
- **LOAD_FEAT**
  - `in_ready`=1.
  - Beat k writes `in_data[31:0]` to feature 2k and `in_data[63:32]` to feature 2k+1.
  - After N_FEATURE/2 beats, go to START.
- **START:** `start`=1 for exactly this one cycle, then WAIT_DONE.
- **WAIT_DONE**
  - `in_ready`=0.
  - On `done`=1, capture `prediction` into `pred_data` and go to RESULT.
  - `done` is ignored in all other states.
- **RESULT**
  - `pred_valid`=1, with `pred_data` held stable until `pred_ready`.
  - A handshake returns to IDLE.
- **Feature register:** changes only on LOAD_FEAT handshakes. It is therefore stable throughout START, WAIT_DONE and RESULT, and persists across inferences.
- **Outputs:** all outputs are registered except `in_ready` and `busy`, which decode the state.

## Timing
- **Reset values:** state IDLE; `in_ready`, `load_trees`, `start`, `pred_valid`, `busy` = 0; `n_tree`, `n_node`, `tree_nodes`, `pred_data`, `features`, all counters = 0.
- **Reset mid-operation:** immediate return to IDLE, with no `start` or `load_trees` pulse emitted. Tree contents already written into `trees` are not cleared.
- **Command latency:** command sampled at edge N; state and `busy` change after that edge; `in_ready`=1 from cycle N+1.
- **Tree writes:** a handshake at edge k produces `load_trees`=1 with matching `n_tree`/`n_node`/`tree_nodes` in cycle k+1 (one write per handshake). `load_trees`=0 in any cycle not following a handshake.
- **Stalls:** `in_valid` gaps are allowed anywhere; the counters hold.
- **Last tree beat:** a handshake at edge k gives IDLE from k+1, and the final `load_trees` pulse is also in k+1.
- **Last feature beat:** a handshake at edge k means the feature register is updated at k, `start`=1 in cycle k+1, and WAIT_DONE begins at k+2.
- **Result:** `done` sampled high at edge d gives `pred_valid`=1 from cycle d+1. A `pred_ready` handshake at edge r drops `pred_valid` in r+1 and returns to IDLE; a command at edge r+1 is accepted.
- **Back-to-back loads:** a new command cannot be accepted in the same edge that completes a phase.

## Test plan
Bench parameters: N_TREES=2, N_NODE_AND_LEAFS=4, N_FEATURE=4.
- **Tree load:** `cmd_load_trees`, then 8 beats with data 0x10..0x17 and `in_valid` held high. Expect 8 `load_trees` pulses with (`n_tree`,`n_node`) going (0,0),(0,1),(0,2),(0,3),(1,0)..(1,3), data 0x10..0x17 in order. `busy` falls the cycle after the 8th handshake.
- **Feature pack:** `cmd_infer`, beats 0x0000000B_0000000A and 0x0000000D_0000000C. Expect features {A,B,C,D} at indices 0..3, a single `start` pulse in the cycle after the 2nd handshake, then `in_ready`=0.
- **Result handshake:** in WAIT_DONE, model drives `done`=1 with `prediction`=0x03, while `pred_ready`=0 for 5 cycles. Expect `pred_valid`=1 with `pred_data`=0x03 held all 5 cycles; when `pred_ready` rises, the handshake occurs and IDLE follows.
- **Stalls and ignored inputs:** toggle `in_valid` every other cycle during the tree load. Expect counters to advance only on handshakes. Assert `cmd_infer` mid-load and expect it to be ignored. Pulse `done` in IDLE and expect no `pred_valid`.
- **Simultaneous commands:** `cmd_load_trees` and `cmd_infer` both high in the same IDLE cycle. Expect LOAD_TREES, then no `start` after the load completes.
- **Reset mid-operation:** assert `rst_n`=0 after the 1st feature beat. Expect all outputs at reset values; the next `cmd_infer` needs 2 fresh beats before `start`.
